// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer port arbiter.
package fb_pkg;

    localparam int FB_ADDR_W       = 18;
    localparam int FB_DATA_W       = 24;
    localparam int FB_FRAME_PIXELS = 197632;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_t;

endpackage

// File: rtl/fb_port_arbiter_fifo.sv
// Small synchronous FIFO buffering pixel-loader writes until the BRAM port is free.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  fb_wr_t                   din,
    output fb_wr_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    fb_wr_t           mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer BRAM arbiter: scanout reads win, loader writes are
// queued and drained on idle cycles or forced in after a bounded read streak.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W        = FB_ADDR_W,
    parameter int DATA_W        = FB_DATA_W,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_RD_STREAK = 8,
    parameter int FRAME_PIXELS  = FB_FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              frame_done,
    output logic              overflow
);

    localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
    localparam int PIX_W    = ADDR_W + 1;

    fb_wr_t                      wr_entry, fifo_head;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full, fifo_empty, fifo_nonempty;
    logic                        force_wr, rd_grant, wr_grant;

    fb_state_e                   state_q, state_d;
    logic [STREAK_W-1:0]         streak_q, streak_d;
    logic [PIX_W-1:0]            pix_q, pix_d;
    logic                        mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]           rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        frame_done_q, frame_done_d;
    logic                        overflow_q, overflow_d;

    assign wr_entry = '{addr: FB_ADDR_W'(wr_addr), data: FB_DATA_W'(wr_data)};

    fb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .pop   (wr_grant),
        .din   (wr_entry),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign fifo_nonempty = !fifo_empty;
    assign force_wr      = fifo_nonempty && (streak_q == STREAK_W'(MAX_RD_STREAK));
    assign rd_grant      = rd_req && !force_wr;
    assign wr_grant      = !rd_grant && fifo_nonempty;

    always_comb begin
        state_d      = S_IDLE;
        streak_d     = streak_q;
        pix_d        = pix_q;
        mem_we_d     = wr_grant;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (wr_en && fifo_full && !wr_grant);

        if (rd_grant) begin
            state_d    = S_READ;
            mem_addr_d = rd_addr;
        end else if (wr_grant) begin
            state_d     = S_WRITE;
            mem_addr_d  = ADDR_W'(fifo_head.addr);
            mem_wdata_d = DATA_W'(fifo_head.data);
        end

        if (wr_grant || !fifo_nonempty)
            streak_d = '0;
        else if (rd_grant && streak_q != STREAK_W'(MAX_RD_STREAK))
            streak_d = streak_q + 1'b1;

        if (wr_grant) begin
            if (pix_q == PIX_W'(FRAME_PIXELS - 1)) begin
                pix_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                pix_d = pix_q + 1'b1;
            end
        end

        // S_READ means the address driven this cycle belongs to a granted read.
        rd_valid_d = (state_q == S_READ);
        rd_data_d  = (state_q == S_READ) ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            streak_q     <= '0;
            pix_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            pix_q        <= pix_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign wr_full    = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
    assign rd_gnt     = rd_grant;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: a default instance plus a short-frame instance.
module tb_fb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [17:0] wr_addr;
    logic [23:0] wr_data;
    logic        rd_req;
    logic [17:0] rd_addr;

    logic        wr_full, rd_gnt, rd_valid, mem_we, frame_done, overflow;
    logic [23:0] rd_data, mem_wdata, mem_rdata;
    logic [17:0] mem_addr;

    logic        wr_full_f, rd_gnt_f, rd_valid_f, mem_we_f, frame_done_f, overflow_f;
    logic [23:0] rd_data_f, mem_wdata_f, mem_rdata_f;
    logic [17:0] mem_addr_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Asynchronous-read memory model: data tracks the registered address.
    assign mem_rdata   = 24'(mem_addr) + 24'h100;
    assign mem_rdata_f = 24'(mem_addr_f) + 24'h100;

    fb_port_arbiter dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_data(rd_data), .rd_valid(rd_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .frame_done(frame_done),
        .overflow(overflow)
    );

    fb_port_arbiter #(.FRAME_PIXELS(4)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_full(wr_full_f), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_f),
        .rd_data(rd_data_f), .rd_valid(rd_valid_f), .mem_we(mem_we_f), .mem_addr(mem_addr_f),
        .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f), .frame_done(frame_done_f),
        .overflow(overflow_f)
    );

    typedef struct {
        logic        wr_en;
        logic [17:0] wa;
        logic [23:0] wd;
        logic        rd_req;
        logic [17:0] ra;
        logic        gnt;
        logic        we;
        logic [17:0] ma;
        logic [23:0] mwd;
        logic        rv;
        logic [23:0] rdat;
        logic        full;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_we"},     32'(mem_we),     32'h0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
        chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
        chk({tag, "_rd_data"},    32'(rd_data),    32'h0);
        chk({tag, "_rd_valid"},   32'(rd_valid),   32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_overflow"},   32'(overflow),   32'h0);
        chk({tag, "_wr_full"},    32'(wr_full),    32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pulses;
        logic exp_we;
        logic exp_fd;

        vt[0] = '{1'b1, 18'h10, 24'hFF8000, 1'b0, 18'h0, 1'b0, 1'b0, 18'h0,  24'h000000, 1'b0, 24'h0,      1'b0};
        vt[1] = '{1'b0, 18'h0,  24'h0,      1'b0, 18'h0, 1'b0, 1'b1, 18'h10, 24'hFF8000, 1'b0, 24'h0,      1'b0};
        vt[2] = '{1'b0, 18'h0,  24'h0,      1'b1, 18'h1, 1'b1, 1'b0, 18'h1,  24'hFF8000, 1'b0, 24'h0,      1'b0};
        vt[3] = '{1'b0, 18'h0,  24'h0,      1'b1, 18'h2, 1'b1, 1'b0, 18'h2,  24'hFF8000, 1'b1, 24'h101,    1'b0};
        vt[4] = '{1'b0, 18'h0,  24'h0,      1'b1, 18'h3, 1'b1, 1'b0, 18'h3,  24'hFF8000, 1'b1, 24'h102,    1'b0};
        vt[5] = '{1'b0, 18'h0,  24'h0,      1'b0, 18'h0, 1'b0, 1'b0, 18'h3,  24'hFF8000, 1'b1, 24'h103,    1'b0};
        vt[6] = '{1'b0, 18'h0,  24'h0,      1'b0, 18'h0, 1'b0, 1'b0, 18'h3,  24'hFF8000, 1'b0, 24'h0,      1'b0};
        vt[7] = '{1'b1, 18'h20, 24'h123456, 1'b1, 18'h7, 1'b1, 1'b0, 18'h7,  24'hFF8000, 1'b0, 24'h0,      1'b0};
        vt[8] = '{1'b0, 18'h0,  24'h0,      1'b0, 18'h0, 1'b0, 1'b1, 18'h20, 24'h123456, 1'b1, 24'h107,    1'b0};
        vt[9] = '{1'b0, 18'h0,  24'h0,      1'b0, 18'h0, 1'b0, 1'b0, 18'h20, 24'h123456, 1'b0, 24'h0,      1'b0};

        rst = 1'b1;
        idle_inputs();
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        // Reset mid-read with a write also queued.
        rd_req = 1'b1; rd_addr = 18'd5;
        wr_en = 1'b1; wr_addr = 18'h77; wr_data = 24'h777777;
        #1 chk("midrd_gnt", 32'(rd_gnt), 32'h1);
        tick();
        chk("midrd_addr", 32'(mem_addr), 32'h5);
        idle_inputs();
        #2 rst = 1'b1;
        #1 chk_all_zero("midrd_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrd_no_valid", 32'(rd_valid), 32'h0);
            chk("midrd_no_drain", 32'(mem_we), 32'h0);
        end

        // Idle write, then read latency, then write queued behind a read.
        for (int i = 0; i < 10; i++) begin
            wr_en = vt[i].wr_en; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_req = vt[i].rd_req; rd_addr = vt[i].ra;
            #1 chk($sformatf("vec%0d_gnt", i), 32'(rd_gnt), 32'(vt[i].gnt));
            tick();
            chk($sformatf("vec%0d_we", i),    32'(mem_we),    32'(vt[i].we));
            chk($sformatf("vec%0d_addr", i),  32'(mem_addr),  32'(vt[i].ma));
            chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vt[i].mwd));
            chk($sformatf("vec%0d_rv", i),    32'(rd_valid),  32'(vt[i].rv));
            chk($sformatf("vec%0d_full", i),  32'(wr_full),   32'(vt[i].full));
            if (vt[i].rv) chk($sformatf("vec%0d_rdata", i), 32'(rd_data), 32'(vt[i].rdat));
        end
        idle_inputs();

        // Starvation guard: continuous reads, one write queued.
        rd_req = 1'b1; rd_addr = 18'h40;
        for (int i = 0; i < 2; i++) begin
            #1 chk("starve_pre_gnt", 32'(rd_gnt), 32'h1);
            tick();
        end
        wr_en = 1'b1; wr_addr = 18'h55; wr_data = 24'hABCDEF;
        #1 chk("starve_push_gnt", 32'(rd_gnt), 32'h1);
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("starve_rd%0d_gnt", i), 32'(rd_gnt), 32'h1);
            tick();
        end
        #1 chk("starve_force_gnt", 32'(rd_gnt), 32'h0);
        tick();
        chk("starve_we",    32'(mem_we),    32'h1);
        chk("starve_addr",  32'(mem_addr),  32'h55);
        chk("starve_wdata", 32'(mem_wdata), 32'hABCDEF);
        for (int i = 0; i < 3; i++) begin
            #1 chk("starve_resume_gnt", 32'(rd_gnt), 32'h1);
            tick();
            chk("starve_resume_we", 32'(mem_we), 32'h0);
        end
        idle_inputs();
        tick();

        // Overflow: reads hold the port while five writes arrive.
        rd_req = 1'b1; rd_addr = 18'h0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_addr = 18'h100 + 18'(i); wr_data = 24'h0A0000 + 24'(i);
            tick();
            chk($sformatf("ovf_full%0d", i), 32'(wr_full), (i >= 3) ? 32'h1 : 32'h0);
            chk($sformatf("ovf_flag%0d", i), 32'(overflow), (i == 4) ? 32'h1 : 32'h0);
        end
        idle_inputs();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mem_we) begin
                chk($sformatf("ovf_drain%0d_addr", n),  32'(mem_addr),  32'h100 + 32'(n));
                chk($sformatf("ovf_drain%0d_wdata", n), 32'(mem_wdata), 32'h0A0000 + 32'(n));
                n++;
            end
        end
        chk("ovf_drain_count", 32'(n), 32'h4);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        chk("ovf_full_after", 32'(wr_full), 32'h0);

        // Frame completion on the FRAME_PIXELS=4 instance.
        do_reset();
        chk("frame_ovf_cleared", 32'(overflow), 32'h0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            wr_en = (c < 8); wr_addr = 18'(c); wr_data = 24'(c);
            tick();
            exp_we = (c >= 1 && c <= 8);
            exp_fd = (c == 4 || c == 8);
            chk($sformatf("frame_c%0d_we", c), 32'(mem_we_f), 32'(exp_we));
            chk($sformatf("frame_c%0d_done", c), 32'(frame_done_f), 32'(exp_fd));
            if (frame_done_f) pulses++;
        end
        idle_inputs();
        chk("frame_pulses", 32'(pulses), 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
